// File: rtl/fifo_drain_serializer_pkg.sv
// Shared definitions for the lrahash FIFO family: state encoding, default
// depth, and small constant/parity helpers used by the drain serializer.
package lrahash_fifo_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Even parity over a beat; narrower beats are zero-extended by the caller,
    // which leaves the parity unchanged.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_drain_serializer_if.sv
// FIFO read side plus narrow valid/ready stream of the drain serializer.
// Optional parity signals exist only when FIFO_DRAIN_PARITY_EN is defined.
interface fifo_drain_serializer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  read_data;
    logic                 read_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 busy;
`ifdef FIFO_DRAIN_PARITY_EN
    logic                 out_parity;
    logic                 parity_chk_fail;
    logic [15:0]          parity_err_cnt;
`endif

    // Serializer side.
    modport master (
        input  fifo_empty, read_data, out_ready,
`ifdef FIFO_DRAIN_PARITY_EN
        input  parity_chk_fail,
        output out_parity, parity_err_cnt,
`endif
        output read_en, out_valid, out_data, out_last, busy
    );

    // FIFO / downstream side.
    modport slave (
        output fifo_empty, read_data, out_ready,
`ifdef FIFO_DRAIN_PARITY_EN
        output parity_chk_fail,
        input  out_parity, parity_err_cnt,
`endif
        input  read_en, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/fifo_drain_serializer.sv
// Pops wide words from a synchronous FIFO and emits each as NUM_BEATS narrow
// beats on a valid/ready stream, reloading on the last-beat accept so there
// is no bubble between words.
// Optional feature macro: FIFO_DRAIN_PARITY_EN (out_parity, parity_chk_fail,
// saturating parity_err_cnt).
module fifo_drain_serializer
    import lrahash_fifo_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_drain_serializer_if.master bus
);

    localparam int NUM_BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W_RAW = clog2(NUM_BEATS);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SEND = SEND;

    logic [0:0]           state_r;
    logic [0:0]           state_nxt_s;
    logic [IN_WIDTH-1:0]  shift_r;
    logic [IN_WIDTH-1:0]  shift_nxt_s;
    logic [CNT_W-1:0]     beat_cnt_r;
    logic [CNT_W-1:0]     beat_cnt_nxt_s;
    logic                 in_send_s;
    logic                 last_s;
    logic                 accept_s;
    logic                 load_s;
    logic [OUT_WIDTH-1:0] out_data_s;

    // Handshake qualifiers: a new word is loaded from IDLE or on the last-beat accept.
    always_comb begin
        in_send_s = (state_r == ST_SEND);
        last_s    = in_send_s && (beat_cnt_r == LAST_BEAT);
        accept_s  = in_send_s && bus.out_ready;
        load_s    = !bus.fifo_empty && (!in_send_s || (accept_s && last_s));
    end

    // Next-state, shift and beat-count logic.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s    = ST_SEND;
                    shift_nxt_s    = bus.read_data;
                    beat_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (accept_s && !last_s) begin
                    // Move the next slice into the output position; vacated bits fill with 0.
                    if (LSB_FIRST) begin
                        shift_nxt_s = shift_r >> OUT_WIDTH;
                    end else begin
                        shift_nxt_s = shift_r << OUT_WIDTH;
                    end
                    beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                end else if (accept_s && load_s) begin
                    shift_nxt_s    = bus.read_data;
                    beat_cnt_nxt_s = {CNT_W{1'b0}};
                end else if (accept_s) begin
                    state_nxt_s    = ST_IDLE;
                    shift_nxt_s    = {IN_WIDTH{1'b0}};
                    beat_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_SEND;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                shift_nxt_s    = {IN_WIDTH{1'b0}};
                beat_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shift register and beat counter; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {IN_WIDTH{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Stream outputs and pop strobe; the pop is held off while reset is asserted.
    always_comb begin
        if (!in_send_s) begin
            out_data_s = {OUT_WIDTH{1'b0}};
        end else if (LSB_FIRST) begin
            out_data_s = shift_r[OUT_WIDTH-1:0];
        end else begin
            out_data_s = shift_r[IN_WIDTH-1 -: OUT_WIDTH];
        end
        bus.out_data  = out_data_s;
        bus.out_valid = in_send_s;
        bus.busy      = in_send_s;
        bus.out_last  = last_s;
        bus.read_en   = load_s && !rst;
    end

`ifdef FIFO_DRAIN_PARITY_EN
    logic [15:0] parity_err_cnt_r;

    // Count accepted beats flagged by downstream parity checking, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_cnt_r <= 16'd0;
        end else if (accept_s && bus.parity_chk_fail && (parity_err_cnt_r != 16'hFFFF)) begin
            parity_err_cnt_r <= parity_err_cnt_r + 16'd1;
        end else begin
            parity_err_cnt_r <= parity_err_cnt_r;
        end
    end

    // Even parity of the current beat (0 in IDLE since out_data is 0 there).
    always_comb begin
        bus.out_parity     = even_parity(64'(out_data_s));
        bus.parity_err_cnt = parity_err_cnt_r;
    end
`endif

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed bench for fifo_drain_serializer: a 32->8 LSB-first instance fed by
// a small FIFO model, a 32->8 MSB-first instance and an 8->8 instance driven
// directly. Parity checks are compiled in with FIFO_DRAIN_PARITY_EN.
module tb_fifo_drain_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   p0;

    always #5 clk = ~clk;

    fifo_drain_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus_a ();
    fifo_drain_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus_b ();
    fifo_drain_serializer_if #(.IN_WIDTH(8),  .OUT_WIDTH(8)) bus_c ();

    fifo_drain_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    fifo_drain_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    fifo_drain_serializer #(.IN_WIDTH(8),  .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .bus(bus_c));

    // Upstream synchronous FIFO model for instance A.
    logic [31:0] mem_a [0:15];
    logic [7:0]  wr_ptr_a    = 8'd0;
    logic [7:0]  rd_ptr_a    = 8'd0;
    int          pops_a      = 0;
    logic        underflow_a = 1'b0;

    assign bus_a.fifo_empty = (wr_ptr_a == rd_ptr_a);
    assign bus_a.read_data  = mem_a[rd_ptr_a[3:0]];

    // FIFO read side: advance on each pop and flag any pop of an empty FIFO.
    always @(posedge clk) begin
        if (bus_a.read_en) begin
            pops_a <= pops_a + 1;
            if (bus_a.fifo_empty) begin
                underflow_a <= 1'b1;
            end else begin
                rd_ptr_a <= rd_ptr_a + 8'd1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        mem_a[wr_ptr_a[3:0]] = w;
        wr_ptr_a = wr_ptr_a + 8'd1;
    endtask

    task automatic check_beat(input string tag, input logic v, input logic [7:0] d, input logic l,
                              input logic [7:0] ed, input logic el);
        check_val({tag, ".valid"}, {31'd0, v}, 32'd1);
        check_val({tag, ".data"},  {24'd0, d}, {24'd0, ed});
        check_val({tag, ".last"},  {31'd0, l}, {31'd0, el});
    endtask

    task automatic beat_a(input string tag, input logic [7:0] ed, input logic el);
        @(negedge clk);
        check_beat(tag, bus_a.out_valid, bus_a.out_data, bus_a.out_last, ed, el);
    endtask

    task automatic beat_b(input string tag, input logic [7:0] ed, input logic el);
        @(negedge clk);
        check_beat(tag, bus_b.out_valid, bus_b.out_data, bus_b.out_last, ed, el);
    endtask

    task automatic idle_a(input string tag);
        @(negedge clk);
        check_val({tag, ".valid"}, {31'd0, bus_a.out_valid}, 32'd0);
        check_val({tag, ".busy"},  {31'd0, bus_a.busy},      32'd0);
        check_val({tag, ".data"},  {24'd0, bus_a.out_data},  32'd0);
        check_val({tag, ".last"},  {31'd0, bus_a.out_last},  32'd0);
    endtask

    initial begin
        bus_a.out_ready  = 1'b0;
        bus_b.out_ready  = 1'b1;
        bus_b.fifo_empty = 1'b1;
        bus_b.read_data  = 32'd0;
        bus_c.out_ready  = 1'b1;
        bus_c.fifo_empty = 1'b1;
        bus_c.read_data  = 8'd0;
`ifdef FIFO_DRAIN_PARITY_EN
        bus_a.parity_chk_fail = 1'b0;
        bus_b.parity_chk_fail = 1'b0;
        bus_c.parity_chk_fail = 1'b0;
`endif

        // Reset state.
        @(negedge clk);
        idle_a("rst");
        check_val("rst.read_en", {31'd0, bus_a.read_en}, 32'd0);
        check_val("rst.b_valid", {31'd0, bus_b.out_valid}, 32'd0);
        check_val("rst.c_valid", {31'd0, bus_c.out_valid}, 32'd0);
`ifdef FIFO_DRAIN_PARITY_EN
        check_val("rst.perr_cnt", {16'd0, bus_a.parity_err_cnt}, 32'd0);
        check_val("rst.parity", {31'd0, bus_a.out_parity}, 32'd0);
`endif
        rst = 1'b0;

        // Single word, LSB first.
        @(negedge clk);
        bus_a.out_ready = 1'b1;
        p0 = pops_a;
        push_a(32'hA1B2C3D4);
        #1;
        check_val("t1.read_en", {31'd0, bus_a.read_en}, 32'd1);
        beat_a("t1.b0", 8'hD4, 1'b0);
        check_val("t1.read_en_b0", {31'd0, bus_a.read_en}, 32'd0);
        beat_a("t1.b1", 8'hC3, 1'b0);
        beat_a("t1.b2", 8'hB2, 1'b0);
        beat_a("t1.b3", 8'hA1, 1'b1);
        idle_a("t1.idle");
        check_val("t1.pops", pops_a - p0, 32'd1);

        // Back-to-back: three preloaded words, beats 00..0B with no gap.
        p0 = pops_a;
        push_a(32'h03020100);
        push_a(32'h07060504);
        push_a(32'h0B0A0908);
        #1;
        check_val("t2.read_en0", {31'd0, bus_a.read_en}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            beat_a($sformatf("t2.k%0d", k), 8'(k), ((k % 4) == 3));
            check_val($sformatf("t2.read_en%0d", k), {31'd0, bus_a.read_en},
                      ((k == 3) || (k == 7)) ? 32'd1 : 32'd0);
            if (k == 8) begin
                check_val("t2.empty", {31'd0, bus_a.fifo_empty}, 32'd1);
            end
        end
        idle_a("t2.idle");
        check_val("t2.pops", pops_a - p0, 32'd3);

        // Backpressure for 5 cycles while beat 2 (0x22) is presented.
        push_a(32'h11223344);
        beat_a("t3.b0", 8'h44, 1'b0);
        beat_a("t3.b1", 8'h33, 1'b0);
        beat_a("t3.b2", 8'h22, 1'b0);
        bus_a.out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            beat_a($sformatf("t3.hold%0d", h), 8'h22, 1'b0);
        end
        bus_a.out_ready = 1'b1;
        beat_a("t3.b3", 8'h11, 1'b1);
        idle_a("t3.idle");

        // Reset after beat 1; second word already queued must restart at beat 0.
        push_a(32'hCAFEF00D);
        push_a(32'h55667788);
        beat_a("t4.b0", 8'h0D, 1'b0);
        beat_a("t4.b1", 8'hF0, 1'b0);
        rst = 1'b1;
        #1;
        check_val("t4.rst_valid", {31'd0, bus_a.out_valid}, 32'd0);
        check_val("t4.rst_data", {24'd0, bus_a.out_data}, 32'd0);
        check_val("t4.rst_last", {31'd0, bus_a.out_last}, 32'd0);
        check_val("t4.rst_busy", {31'd0, bus_a.busy}, 32'd0);
        check_val("t4.rst_read_en", {31'd0, bus_a.read_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("t4.read_en", {31'd0, bus_a.read_en}, 32'd1);
        beat_a("t4.n0", 8'h88, 1'b0);
        beat_a("t4.n1", 8'h77, 1'b0);
        beat_a("t4.n2", 8'h66, 1'b0);
        beat_a("t4.n3", 8'h55, 1'b1);
        idle_a("t4.idle");

        // MSB first on instance B.
        bus_b.read_data  = 32'h12345678;
        bus_b.fifo_empty = 1'b0;
        #1;
        check_val("t5.read_en", {31'd0, bus_b.read_en}, 32'd1);
        beat_b("t5.b0", 8'h12, 1'b0);
        bus_b.fifo_empty = 1'b1;
        beat_b("t5.b1", 8'h34, 1'b0);
        beat_b("t5.b2", 8'h56, 1'b0);
        beat_b("t5.b3", 8'h78, 1'b1);
        check_val("t5.read_en_last", {31'd0, bus_b.read_en}, 32'd0);
        @(negedge clk);
        check_val("t5.idle_valid", {31'd0, bus_b.out_valid}, 32'd0);

        // One beat per word on instance C, one word per cycle.
        bus_c.read_data  = 8'h5A;
        bus_c.fifo_empty = 1'b0;
        #1;
        check_val("t6.read_en0", {31'd0, bus_c.read_en}, 32'd1);
        @(negedge clk);
        check_beat("t6.w0", bus_c.out_valid, bus_c.out_data, bus_c.out_last, 8'h5A, 1'b1);
        bus_c.read_data = 8'hA5;
        #1;
        check_val("t6.read_en1", {31'd0, bus_c.read_en}, 32'd1);
        @(negedge clk);
        check_beat("t6.w1", bus_c.out_valid, bus_c.out_data, bus_c.out_last, 8'hA5, 1'b1);
        bus_c.fifo_empty = 1'b1;
        #1;
        check_val("t6.read_en2", {31'd0, bus_c.read_en}, 32'd0);
        @(negedge clk);
        check_val("t6.idle_valid", {31'd0, bus_c.out_valid}, 32'd0);

        // Empty FIFO with out_ready high: nothing pops, nothing is sent.
        bus_a.out_ready = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            check_val($sformatf("t7.read_en%0d", e), {31'd0, bus_a.read_en}, 32'd0);
            check_val($sformatf("t7.valid%0d", e), {31'd0, bus_a.out_valid}, 32'd0);
        end

`ifdef FIFO_DRAIN_PARITY_EN
        // Parity of beat 0x07 is 1; every accepted beat is flagged as a check failure.
        bus_a.parity_chk_fail = 1'b1;
        push_a(32'h00000007);
        beat_a("t8.b0", 8'h07, 1'b0);
        check_val("t8.parity0", {31'd0, bus_a.out_parity}, 32'd1);
        beat_a("t8.b1", 8'h00, 1'b0);
        check_val("t8.parity1", {31'd0, bus_a.out_parity}, 32'd0);
        beat_a("t8.b2", 8'h00, 1'b0);
        beat_a("t8.b3", 8'h00, 1'b1);
        idle_a("t8.idle");
        bus_a.parity_chk_fail = 1'b0;
        check_val("t8.perr_cnt", {16'd0, bus_a.parity_err_cnt}, 32'd4);
        check_val("t8.parity_idle", {31'd0, bus_a.out_parity}, 32'd0);
`endif

        check_val("underflow", {31'd0, underflow_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
